id_stage: RTL

- Pipelined RV32I decode stage between instruction fetch (IF) and execute (EX).
- Decodes each accepted instruction into its type, ALU operands, immediate, ALU sub-op code and register read/write controls.
- Registers the result in a one-entry output buffer with valid/ready handshakes on both sides.
- Adds load-use stall, flush and store/branch/load decode; it replaces the single-cycle combinational decoder.

---
 rtl/id_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_stage
// Brief   : RV32I decode stage with a one-entry output buffer, valid/ready
//           handshakes, load-use stall and flush. Optional illegal-instruction
//           flag enabled by defining ID_ILLEGAL_INST_EN.
// Revision: 1.0
// ============================================================================
module id_stage #(
    parameter int XLEN     = 32,
    parameter int ALUCEX_W = 8,
    parameter int TYPE_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [XLEN-1:0]     in_pc,
    output logic [4:0]          reg_rs1_addr,
    output logic [4:0]          reg_rs2_addr,
    output logic                reg_rs1_ren,
    output logic                reg_rs2_ren,
    input  logic [XLEN-1:0]     reg_rs1_data,
    input  logic [XLEN-1:0]     reg_rs2_data,
    input  logic                ex_load_valid,
    input  logic [4:0]          ex_load_rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [TYPE_W-1:0]   out_type,
    output logic [ALUCEX_W-1:0] out_alucex,
    output logic [XLEN-1:0]     out_op_a,
    output logic [XLEN-1:0]     out_op_b,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_store_data,
    output logic                out_rd_wen,
`ifdef ID_ILLEGAL_INST_EN
    output logic                out_illegal,
`endif
    output logic [4:0]          out_rd_addr
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [TYPE_W-1:0] NO_TYPE     = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] R_TYPE      = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] I_TYPE      = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] LOAD_TYPE   = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] STORE_TYPE  = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] BRANCH_TYPE = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] J_TYPE      = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] JALR_TYPE   = TYPE_W'(7);
    localparam logic [TYPE_W-1:0] LUI_TYPE    = TYPE_W'(8);
    localparam logic [TYPE_W-1:0] AUIPC_TYPE  = TYPE_W'(9);
    localparam logic [TYPE_W-1:0] SYSTEM_TYPE = TYPE_W'(10);

    localparam logic [ALUCEX_W-1:0] ALU_ADD    = ALUCEX_W'(8'h01);
    localparam logic [ALUCEX_W-1:0] ALU_SUB    = ALUCEX_W'(8'h02);
    localparam logic [ALUCEX_W-1:0] ALU_SLL    = ALUCEX_W'(8'h03);
    localparam logic [ALUCEX_W-1:0] ALU_SLT    = ALUCEX_W'(8'h04);
    localparam logic [ALUCEX_W-1:0] ALU_SLTU   = ALUCEX_W'(8'h05);
    localparam logic [ALUCEX_W-1:0] ALU_XOR    = ALUCEX_W'(8'h06);
    localparam logic [ALUCEX_W-1:0] ALU_SRL    = ALUCEX_W'(8'h07);
    localparam logic [ALUCEX_W-1:0] ALU_SRA    = ALUCEX_W'(8'h08);
    localparam logic [ALUCEX_W-1:0] ALU_OR     = ALUCEX_W'(8'h09);
    localparam logic [ALUCEX_W-1:0] ALU_AND    = ALUCEX_W'(8'h0A);
    localparam logic [ALUCEX_W-1:0] ALU_LOAD   = ALUCEX_W'(8'h10);
    localparam logic [ALUCEX_W-1:0] ALU_STORE  = ALUCEX_W'(8'h11);
    localparam logic [ALUCEX_W-1:0] ALU_BRANCH = ALUCEX_W'(8'h12);
    localparam logic [ALUCEX_W-1:0] ALU_JAL    = ALUCEX_W'(8'h13);
    localparam logic [ALUCEX_W-1:0] ALU_JALR   = ALUCEX_W'(8'h14);
    localparam logic [ALUCEX_W-1:0] ALU_LUI    = ALUCEX_W'(8'h15);
    localparam logic [ALUCEX_W-1:0] ALU_AUIPC  = ALUCEX_W'(8'h16);
    localparam logic [ALUCEX_W-1:0] ALU_SYSTEM = ALUCEX_W'(8'h17);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    function automatic logic [ALUCEX_W-1:0] arith_op(input logic [2:0] f3,
                                                     input logic alt_sub,
                                                     input logic alt_sra);
        case (f3)
            3'b000:  return alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [4:0]          rs1, rs2, rd;
    logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_j, imm_u;
    logic                rs1_used, rs2_used, wr_kind, known, illegal_d;
    logic                hazard, xfer_in, rd_wen_d;
    logic [TYPE_W-1:0]   type_d;
    logic [ALUCEX_W-1:0] alucex_d;
    logic [XLEN-1:0]     op_a_d, op_b_d, imm_d, store_data_d;
    logic [4:0]          rd_addr_d;

    logic                valid_q, rd_wen_q, illegal_q;
    logic [XLEN-1:0]     pc_q, op_a_q, op_b_q, imm_q, store_data_q;
    logic [TYPE_W-1:0]   type_q;
    logic [ALUCEX_W-1:0] alucex_q;
    logic [4:0]          rd_addr_q;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];

    assign imm_i = sext32({{20{in_inst[31]}}, in_inst[31:20]});
    assign imm_s = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
    assign imm_b = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0});
    assign imm_j = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0});
    assign imm_u = sext32({in_inst[31:12], 12'b0});

    always_comb begin
        type_d       = NO_TYPE;
        alucex_d     = '0;
        op_a_d       = '0;
        op_b_d       = '0;
        imm_d        = '0;
        store_data_d = '0;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        wr_kind      = 1'b0;
        known        = 1'b1;
        case (opcode)
            OPC_R: begin
                type_d = R_TYPE; alucex_d = arith_op(f3, in_inst[30], in_inst[30]);
                op_a_d = reg_rs1_data; op_b_d = reg_rs2_data;
                rs1_used = 1'b1; rs2_used = 1'b1; wr_kind = 1'b1;
            end
            OPC_I: begin
                type_d = I_TYPE; alucex_d = arith_op(f3, 1'b0, in_inst[30]);
                op_a_d = reg_rs1_data; op_b_d = imm_i;
                rs1_used = 1'b1; wr_kind = 1'b1;
            end
            OPC_LOAD: begin
                type_d = LOAD_TYPE; alucex_d = ALU_LOAD;
                op_a_d = reg_rs1_data; op_b_d = imm_i;
                rs1_used = 1'b1; wr_kind = 1'b1;
            end
            OPC_STORE: begin
                type_d = STORE_TYPE; alucex_d = ALU_STORE;
                op_a_d = reg_rs1_data; op_b_d = imm_s; imm_d = imm_s;
                store_data_d = reg_rs2_data;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_BRANCH: begin
                type_d = BRANCH_TYPE; alucex_d = ALU_BRANCH;
                op_a_d = reg_rs1_data; op_b_d = reg_rs2_data; imm_d = imm_b;
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_JAL: begin
                type_d = J_TYPE; alucex_d = ALU_JAL;
                op_a_d = imm_j; op_b_d = in_pc; wr_kind = 1'b1;
            end
            OPC_JALR: begin
                type_d = JALR_TYPE; alucex_d = ALU_JALR;
                op_a_d = reg_rs1_data; op_b_d = imm_i;
                rs1_used = 1'b1; wr_kind = 1'b1;
            end
            OPC_LUI: begin
                type_d = LUI_TYPE; alucex_d = ALU_LUI; op_a_d = imm_u; wr_kind = 1'b1;
            end
            OPC_AUIPC: begin
                type_d = AUIPC_TYPE; alucex_d = ALU_AUIPC;
                op_a_d = imm_u; op_b_d = in_pc; wr_kind = 1'b1;
            end
            OPC_SYSTEM: begin
                type_d = SYSTEM_TYPE; alucex_d = ALU_SYSTEM;
            end
            default: known = 1'b0;
        endcase
    end

`ifdef ID_ILLEGAL_INST_EN
    assign illegal_d = !known || (in_inst[1:0] != 2'b11)
                    || ((opcode == OPC_R) && (in_inst[31:25] != 7'b0000000)
                                          && (in_inst[31:25] != 7'b0100000))
                    || ((opcode == OPC_SYSTEM) && ((f3 != 3'b000) || (in_inst[31:20] > 12'd1)));
    assign out_illegal = illegal_q;
`else
    assign illegal_d = 1'b0;
`endif

    // Unknown opcodes carry no destination at all, not just a cleared enable.
    assign rd_addr_d = known ? rd : 5'd0;
    assign rd_wen_d  = wr_kind && (rd != 5'd0) && !illegal_d;

    assign reg_rs1_addr = rs1;
    assign reg_rs2_addr = rs2;
    assign reg_rs1_ren  = in_valid && rs1_used;
    assign reg_rs2_ren  = in_valid && rs2_used;

    assign hazard   = in_valid && ex_load_valid && (ex_load_rd != 5'd0)
                   && ((rs1_used && (rs1 == ex_load_rd)) || (rs2_used && (rs2 == ex_load_rd)));
    assign in_ready = flush || (!hazard && (!valid_q || out_ready));
    assign xfer_in  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            type_q       <= '0;
            alucex_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            imm_q        <= '0;
            store_data_q <= '0;
            rd_wen_q     <= 1'b0;
            rd_addr_q    <= '0;
            illegal_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!valid_q || out_ready) begin
            valid_q <= xfer_in;
            if (xfer_in) begin
                pc_q         <= in_pc;
                type_q       <= type_d;
                alucex_q     <= alucex_d;
                op_a_q       <= op_a_d;
                op_b_q       <= op_b_d;
                imm_q        <= imm_d;
                store_data_q <= store_data_d;
                rd_wen_q     <= rd_wen_d;
                rd_addr_q    <= rd_addr_d;
                illegal_q    <= illegal_d;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_type       = type_q;
    assign out_alucex     = alucex_q;
    assign out_op_a       = op_a_q;
    assign out_op_b       = op_b_q;
    assign out_imm        = imm_q;
    assign out_store_data = store_data_q;
    assign out_rd_wen     = rd_wen_q;
    assign out_rd_addr    = rd_addr_q;

endmodule
`default_nettype wire
